// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Receives operand A, operand B and opcode as three UART bytes and drives the
// ALU input registers. One cycle later it captures the combinational ALU result
// and hands it to the UART transmitter with a start/done handshake.
// Optional feature: define ALU_IF_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES idle cycles in GET_B/GET_OP (o_timeout_err pulses once).
//
// state    | meaning
// ---------+------------------------------------------------------------
// GET_A    | waiting for operand A byte
// GET_B    | waiting for operand B byte
// GET_OP   | waiting for opcode byte
// EXEC     | one settle cycle for the ALU; result captured at its end
// WAIT_TX  | result byte handed to transmitter, waiting for i_tx_done

module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_alu_data_A,
  output logic [NB_DATA-1:0] o_alu_data_B,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout_err
);

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_EXEC,
    ST_WAIT_TX
  } state_t;

  state_t state, state_next;

  logic load_a;
  logic load_b;
  logic load_op;
  logic load_tx;
  logic drop_byte;
  logic tmo_hit;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] tmo_cnt;
  logic              in_partial;

  assign in_partial = (state == ST_GET_B) || (state == ST_GET_OP);
  assign tmo_hit    = in_partial && !i_rx_done && (tmo_cnt == CNT_LAST);

  // Idle counter inside a partial frame; restarts on any byte or state change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if (i_rx_done || (state_next != state) || !in_partial) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + NB_CNT'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit            = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_GET_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the load/drop strobes for the datapath registers.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_tx    = 1'b0;
    drop_byte  = 1'b0;
    case (state)
      ST_GET_A: begin
        if (i_rx_done) begin
          load_a     = 1'b1;
          state_next = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          load_b     = 1'b1;
          state_next = ST_GET_OP;
        end else if (tmo_hit) begin
          state_next = ST_GET_A;
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          load_op    = 1'b1;
          state_next = ST_EXEC;
        end else if (tmo_hit) begin
          state_next = ST_GET_A;
        end
      end
      ST_EXEC: begin
        load_tx    = 1'b1;
        drop_byte  = i_rx_done;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          // A byte arriving with tx_done is the start of the next frame.
          if (i_rx_done) begin
            load_a     = 1'b1;
            state_next = ST_GET_B;
          end else begin
            state_next = ST_GET_A;
          end
        end else begin
          drop_byte = i_rx_done;
        end
      end
      default: state_next = ST_GET_A;
    endcase
  end

  // Operand/opcode/result registers, start pulse and error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_data_A  <= '0;
      o_alu_data_B  <= '0;
      o_alu_op      <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_overrun     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      if (load_a) begin
        o_alu_data_A <= i_rx_data;
      end
      if (load_b) begin
        o_alu_data_B <= i_rx_data;
      end
      if (load_op) begin
        o_alu_op <= i_rx_data[NB_OP-1:0];
      end
      if (load_tx) begin
        o_tx_data <= i_alu_result;
      end
      if (drop_byte) begin
        o_overrun <= 1'b1;
      end
      o_tx_start    <= load_tx;
      o_timeout_err <= tmo_hit;
    end
  end

  assign o_busy = (state == ST_EXEC) || (state == ST_WAIT_TX);

endmodule
